// File: rtl/math_pkg.sv
// Shared types and helpers for the abs/peak datapath.
// MATH_ABS_RES_T(W) builds the per-lane {sat, mag} result struct for a given width.
`define MATH_ABS_RES_T(W) struct packed { logic sat; logic [(W)-1:0] mag; }

package math_pkg;

    localparam int SAT_CNT_W = 32;
    localparam int ABS_MAX_W = 64;

    // x is a W-bit sample sign-extended to ABS_MAX_W; returns {sat, mag}, mag valid in the low w bits.
    function automatic logic [ABS_MAX_W:0] abs_sat(input logic [ABS_MAX_W-1:0] x,
                                                   input int unsigned         w,
                                                   input bit                  sat_en);
        logic [ABS_MAX_W-1:0] min_neg;
        logic [ABS_MAX_W-1:0] mag;
        logic                 sat;
        min_neg = ~((ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1));
        sat     = (x == min_neg);
        mag     = x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
        if (sat)
            mag = sat_en ? ((ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1))
                         : (ABS_MAX_W'(1) << (w - 1));
        return {sat, mag};
    endfunction

endpackage

// File: rtl/math_abs_lane.sv
// One channel: combinational abs/saturate of the ingress sample plus the peak-hold register.
// Peak decay is built only when MATH_ABS_PEAK_DECAY_EN is defined.
module math_abs_lane
    import math_pkg::*;
#(
    parameter int DATA_WIDTH_P  = 16,
    parameter int SATURATE_P    = 1
`ifdef MATH_ABS_PEAK_DECAY_EN
   ,parameter int DECAY_SHIFT_P = 3
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] sample,
    output logic [DATA_WIDTH_P-1:0] mag,
    output logic                    sat,
    input  logic                    hs,
    input  logic                    clr,
`ifdef MATH_ABS_PEAK_DECAY_EN
    input  logic                    decay_step,
`endif
    input  logic [DATA_WIDTH_P-1:0] egr_mag,
    output logic [DATA_WIDTH_P-1:0] peak
);

    typedef `MATH_ABS_RES_T(DATA_WIDTH_P) res_t;

    logic [ABS_MAX_W:0]              abs_wide;
    logic [ABS_MAX_W-1:DATA_WIDTH_P] unused_abs_hi;
    res_t                            res;
    logic [DATA_WIDTH_P-1:0]         base;

    assign abs_wide      = abs_sat(ABS_MAX_W'($signed(sample)), DATA_WIDTH_P, SATURATE_P != 0);
    assign res           = {abs_wide[ABS_MAX_W], abs_wide[DATA_WIDTH_P-1:0]};
    assign unused_abs_hi = abs_wide[ABS_MAX_W-1:DATA_WIDTH_P];
    assign mag           = res.mag;
    assign sat           = res.sat;

    // Clear wins over decay; the current beat is then max'ed against what is left.
    always_comb begin
        base = peak;
`ifdef MATH_ABS_PEAK_DECAY_EN
        if (decay_step)
            base = peak - (peak >> DECAY_SHIFT_P);
`endif
        if (clr)
            base = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= '0;
        else if (hs && (egr_mag > base))
            peak <= egr_mag;
        else
            peak <= base;
    end

endmodule

// File: rtl/math_abs_peak.sv
// Multi-channel streaming abs unit: 2-stage valid/ready pipeline, per-channel peak hold, sat counter.
// Optional peak decay (counter + shift-decay) is enabled by defining MATH_ABS_PEAK_DECAY_EN.
module math_abs_peak
    import math_pkg::*;
#(
    parameter int DATA_WIDTH_P     = 16,
    parameter int NR_OF_CHANNELS_P = 4,
    parameter int SATURATE_P       = 1,
    parameter int DECAY_PERIOD_P   = 256,
    parameter int DECAY_SHIFT_P    = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ing_tvalid,
    output logic                                   ing_tready,
    input  logic [NR_OF_CHANNELS_P*DATA_WIDTH_P-1:0] ing_tdata,
    output logic                                   egr_tvalid,
    input  logic                                   egr_tready,
    output logic [NR_OF_CHANNELS_P*DATA_WIDTH_P-1:0] egr_tdata,
    output logic [NR_OF_CHANNELS_P-1:0]            egr_tsat,
    input  logic                                   cr_peak_clear,
    output logic [NR_OF_CHANNELS_P*DATA_WIDTH_P-1:0] sr_peak,
    output logic [SAT_CNT_W-1:0]                   sr_sat_count
);

    localparam int W = DATA_WIDTH_P;
    localparam int N = NR_OF_CHANNELS_P;

    logic [N-1:0][W-1:0] abs_mag, s1_mag, egr_mag, peak;
    logic [N-1:0]        abs_flag, s1_sat;
    logic                s1_valid, s1_adv, s2_adv, egr_hs;
    logic [SAT_CNT_W-1:0] sat_add;
    logic [SAT_CNT_W:0]   sat_sum;

    assign s2_adv     = !egr_tvalid || egr_tready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign ing_tready = s1_adv && !rst;
    assign egr_hs     = egr_tvalid && egr_tready;
    assign egr_tdata  = egr_mag;
    assign sr_peak    = peak;

`ifdef MATH_ABS_PEAK_DECAY_EN
    localparam int CNT_W = (DECAY_PERIOD_P > 1) ? $clog2(DECAY_PERIOD_P) : 1;
    logic [CNT_W-1:0] decay_cnt;
    logic             decay_step;

    assign decay_step = egr_hs && (decay_cnt == CNT_W'(DECAY_PERIOD_P - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            decay_cnt <= '0;
        else if (egr_hs)
            decay_cnt <= decay_step ? '0 : decay_cnt + CNT_W'(1);
    end
`else
    logic unused_decay_cfg;
    assign unused_decay_cfg = ^{DECAY_PERIOD_P, DECAY_SHIFT_P};
`endif

    for (genvar k = 0; k < N; k++) begin : g_lane
        math_abs_lane #(
            .DATA_WIDTH_P (W),
            .SATURATE_P   (SATURATE_P)
`ifdef MATH_ABS_PEAK_DECAY_EN
           ,.DECAY_SHIFT_P(DECAY_SHIFT_P)
`endif
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .sample     (ing_tdata[k*W +: W]),
            .mag        (abs_mag[k]),
            .sat        (abs_flag[k]),
            .hs         (egr_hs),
            .clr        (cr_peak_clear),
`ifdef MATH_ABS_PEAK_DECAY_EN
            .decay_step (decay_step),
`endif
            .egr_mag    (egr_mag[k]),
            .peak       (peak[k])
        );
    end

    // Each stage loads when empty or when the stage after it drains this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_mag     <= '0;
            s1_sat     <= '0;
            egr_tvalid <= 1'b0;
            egr_mag    <= '0;
            egr_tsat   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= ing_tvalid;
                if (ing_tvalid) begin
                    s1_mag <= abs_mag;
                    s1_sat <= abs_flag;
                end
            end
            if (s2_adv) begin
                egr_tvalid <= s1_valid;
                if (s1_valid) begin
                    egr_mag  <= s1_mag;
                    egr_tsat <= s1_sat;
                end
            end
        end
    end

    always_comb begin
        sat_add = '0;
        for (int k = 0; k < N; k++)
            sat_add = sat_add + SAT_CNT_W'(egr_tsat[k]);
    end

    assign sat_sum = {1'b0, sr_sat_count} + {1'b0, sat_add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr_sat_count <= '0;
        else if (egr_hs)
            sr_sat_count <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
    end

endmodule

// File: tb/tb_math_abs_peak.sv
// Scoreboard bench for math_abs_peak: clipping DUT under random backpressure plus a wrapping DUT
// that is always ready; a behavioural model predicts data, flags, peaks and the sat count.
module tb_math_abs_peak;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int PER = 4;
    localparam int SH  = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           ing_tvalid, ing_tready, egr_tvalid, egr_tready, cr_peak_clear;
    logic [N*W-1:0] ing_tdata, egr_tdata, sr_peak;
    logic [N-1:0]   egr_tsat;
    logic [31:0]    sr_sat_count;

    logic           w_ing_tready, w_egr_tvalid;
    logic [N*W-1:0] w_egr_tdata, w_sr_peak;
    logic [N-1:0]   w_egr_tsat;
    logic [31:0]    w_sr_sat_count;

    always #5 clk = ~clk;

    math_abs_peak #(.DATA_WIDTH_P(W), .NR_OF_CHANNELS_P(N), .SATURATE_P(1),
                    .DECAY_PERIOD_P(PER), .DECAY_SHIFT_P(SH)) u_dut (
        .clk(clk), .rst(rst),
        .ing_tvalid(ing_tvalid), .ing_tready(ing_tready), .ing_tdata(ing_tdata),
        .egr_tvalid(egr_tvalid), .egr_tready(egr_tready), .egr_tdata(egr_tdata), .egr_tsat(egr_tsat),
        .cr_peak_clear(cr_peak_clear), .sr_peak(sr_peak), .sr_sat_count(sr_sat_count));

    math_abs_peak #(.DATA_WIDTH_P(W), .NR_OF_CHANNELS_P(N), .SATURATE_P(0),
                    .DECAY_PERIOD_P(PER), .DECAY_SHIFT_P(SH)) u_wrap (
        .clk(clk), .rst(rst),
        .ing_tvalid(ing_tvalid), .ing_tready(w_ing_tready), .ing_tdata(ing_tdata),
        .egr_tvalid(w_egr_tvalid), .egr_tready(1'b1), .egr_tdata(w_egr_tdata), .egr_tsat(w_egr_tsat),
        .cr_peak_clear(1'b0), .sr_peak(w_sr_peak), .sr_sat_count(w_sr_sat_count));

    typedef struct {
        logic [N*W-1:0] data;
        logic [N-1:0]   sat;
    } beat_t;

    beat_t        q[$];
    beat_t        qw[$];
    int           checks = 0;
    int           errors = 0;
    int           pk[N];
    longint       satc;
    int           dcnt;
    logic         prev_stall;
    logic [N*W+N-1:0] prev_out;
    bit           rand_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t ref_beat(input logic [N*W-1:0] raw, input bit clip);
        beat_t b;
        int    v;
        for (int k = 0; k < N; k++) begin
            v = int'($signed(raw[k*W +: W]));
            if (v < 0) v = -v;
            b.sat[k] = (v == (1 << (W - 1)));
            if (b.sat[k] && clip) v = (1 << (W - 1)) - 1;
            b.data[k*W +: W] = v[W-1:0];
        end
        return b;
    endfunction

    function automatic logic [N*W-1:0] model_peak();
        logic [N*W-1:0] p;
        for (int k = 0; k < N; k++) p[k*W +: W] = pk[k][W-1:0];
        return p;
    endfunction

    function automatic logic [N*W-1:0] rnd_beat();
        logic [N*W-1:0] d;
        logic [W-1:0]   s;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 7))
                0:       s = 16'h8000;
                1:       s = 16'h7FFF;
                2:       s = 16'h0000;
                3:       s = 16'hFFFF;
                default: s = W'($urandom);
            endcase
            d[k*W +: W] = s;
        end
        return d;
    endfunction

    task automatic apply_egress(input beat_t e, input bit clr);
        bit dec = 1'b0;
        int m;
`ifdef MATH_ABS_PEAK_DECAY_EN
        dcnt++;
        if (dcnt == PER) begin
            dcnt = 0;
            dec  = 1'b1;
        end
`endif
        for (int k = 0; k < N; k++) begin
            m = int'(e.data[k*W +: W]);
            if (clr) pk[k] = 0;
            else if (dec) pk[k] = pk[k] - pk[k] / (2 ** SH);
            if (m > pk[k]) pk[k] = m;
        end
        satc += $countones(e.sat);
        if (satc > 64'hFFFF_FFFF) satc = 64'hFFFF_FFFF;
    endtask

    // Monitor: samples mid-cycle, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            chk("rst_ing_tready", ing_tready, 0);
            chk("rst_egr_tvalid", egr_tvalid, 0);
            chk("rst_sr_peak", sr_peak, 0);
            chk("rst_sat_count", sr_sat_count, 0);
            q.delete();
            qw.delete();
            for (int k = 0; k < N; k++) pk[k] = 0;
            satc       = 0;
            dcnt       = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_tvalid", egr_tvalid, 1);
                chk("hold_data", {egr_tsat, egr_tdata}, prev_out);
            end
            chk("sr_peak", sr_peak, model_peak());
            chk("sr_sat_count", sr_sat_count, satc[31:0]);
            if (ing_tvalid && ing_tready) q.push_back(ref_beat(ing_tdata, 1'b1));
            if (ing_tvalid && w_ing_tready) qw.push_back(ref_beat(ing_tdata, 1'b0));
            if (egr_tvalid && egr_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL egr_unexpected: got beat %0h expected none", egr_tdata);
                end else begin
                    e = q.pop_front();
                    chk("egr_tdata", egr_tdata, e.data);
                    chk("egr_tsat", egr_tsat, e.sat);
                    apply_egress(e, cr_peak_clear);
                end
            end else if (cr_peak_clear) begin
                for (int k = 0; k < N; k++) pk[k] = 0;
            end
            if (w_egr_tvalid) begin
                if (qw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_unexpected: got beat %0h expected none", w_egr_tdata);
                end else begin
                    e = qw.pop_front();
                    chk("wrap_tdata", w_egr_tdata, e.data);
                    chk("wrap_tsat", w_egr_tsat, e.sat);
                end
            end
            prev_stall = egr_tvalid && !egr_tready;
            prev_out   = {egr_tsat, egr_tdata};
        end
    end

    // Sole driver of egr_tready: random while rand_bp, otherwise always ready.
    initial begin
        egr_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            egr_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_dir(input logic [N*W-1:0] d, input bit check_lat, input bit clr_at_out);
        bit hs = 1'b0;
        ing_tvalid = 1'b1;
        ing_tdata  = d;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = ing_tready;
            @(posedge clk);
            #1;
        end
        ing_tvalid = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no ingress handshake expected one within 50 cycles");
            return;
        end
        if (check_lat) chk("latency_cycle1_tvalid", egr_tvalid, 0);
        @(posedge clk);
        #1;
        if (check_lat) chk("latency_cycle2_tvalid", egr_tvalid, 1);
        if (clr_at_out) cr_peak_clear = 1'b1;
        @(posedge clk);
        #1;
        cr_peak_clear = 1'b0;
    endtask

    task automatic clear_pulse();
        cr_peak_clear = 1'b1;
        @(posedge clk);
        #1;
        cr_peak_clear = 1'b0;
    endtask

    initial begin
        int  sent, cyc;
        bit  hs;
        rst           = 1'b1;
        ing_tvalid    = 1'b0;
        ing_tdata     = '0;
        cr_peak_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", ing_tready, 1);
        chk("tvalid_after_reset", egr_tvalid, 0);
        chk("tdata_after_reset", egr_tdata, 0);
        chk("tsat_after_reset", egr_tsat, 0);

        send_dir({16'hFFFB, 16'h0007}, 1'b1, 1'b0);
        chk("peak_after_5_7", sr_peak, {16'd5, 16'd7});
        send_dir({16'h0000, 16'h8000}, 1'b1, 1'b0);
        chk("sat_count_after_min", sr_sat_count, 1);
        chk("peak_after_min", sr_peak, {16'd5, 16'd32767});

        clear_pulse();
        chk("peak_clear_idle", sr_peak, 0);
        send_dir({16'd300, 16'd9}, 1'b0, 1'b0);
        chk("peak_300_9", sr_peak, {16'd300, 16'd9});
        send_dir({16'hFFFC, 16'd2}, 1'b0, 1'b1);
        chk("peak_clear_with_beat", sr_peak, {16'd4, 16'd2});
        clear_pulse();
        chk("peak_clear_no_beat", sr_peak, 0);

        rand_bp = 1'b1;
        sent    = 0;
        hs      = 1'b0;
        for (cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
            if (!ing_tvalid || hs) begin
                ing_tvalid = 1'($urandom_range(0, 1));
                ing_tdata  = rnd_beat();
            end
            @(negedge clk);
            hs = ing_tvalid && ing_tready;
            @(posedge clk);
            #1;
            if (hs) sent++;
        end
        ing_tvalid = 1'b0;
        chk("random_beats_sent", sent, 100);
        rand_bp = 1'b0;
        for (cyc = 0; cyc < 200 && (q.size() != 0 || qw.size() != 0 || egr_tvalid); cyc++)
            @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_wrap_queue_empty", qw.size(), 0);

        ing_tvalid = 1'b1;
        ing_tdata  = {16'h8000, 16'h1234};
        @(posedge clk);
        #1;
        ing_tdata  = {16'hF000, 16'h0555};
        @(posedge clk);
        #1;
        ing_tvalid = 1'b0;
        rst        = 1'b1;
        #1;
        chk("midrst_egr_tvalid", egr_tvalid, 0);
        chk("midrst_sr_peak", sr_peak, 0);
        chk("midrst_sat_count", sr_sat_count, 0);
        chk("midrst_ing_tready", ing_tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        send_dir({16'd1000, 16'd1000}, 1'b1, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            send_dir('0, 1'b0, 1'b0);
`ifdef MATH_ABS_PEAK_DECAY_EN
            if (i == 4) chk("decay_after_4", sr_peak, {16'd500, 16'd500});
            if (i == 8) chk("decay_after_8", sr_peak, {16'd250, 16'd250});
`else
            if (i == 4) chk("hold_after_4", sr_peak, {16'd1000, 16'd1000});
            if (i == 8) chk("hold_after_8", sr_peak, {16'd1000, 16'd1000});
`endif
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
